// File: rtl/uram_rd_stream.sv
// uram_rd_stream: streams a wrapping range of URAM words to a ready/valid sink with credit-based flow control
module uram_rd_stream #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 64,
  parameter int DATA_DEPTH = 3100,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  output logic                  ram_enb,
  input  logic [DATA_WIDTH-1:0] ram_doutb,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast
);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] addr, last_addr, remaining;
  logic [1:0] vld, lst;
  logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic accept, credit, last_rd, pop;
  assign cmd_ready = rst_n && state == IDLE;
  assign accept = cmd_valid && cmd_ready;
  // a read may only issue if its data is guaranteed a FIFO slot, counting reads still in the RAM pipeline
  assign credit = 32'(count) + 32'(vld[0]) + 32'(vld[1]) < 32'(FIFO_DEPTH);
  assign ram_enb = state == READ && credit;
  assign ram_addrb = ram_enb ? addr : last_addr;
  assign last_rd = ram_enb && remaining == '0;
  assign m_tvalid = count != '0;
  assign {m_tlast, m_tdata} = m_tvalid ? mem[rd_ptr] : '0;
  assign pop = m_tvalid && m_tready;
  // next-state: stay in DRAIN until the tagged last beat leaves the FIFO
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = READ;
      READ:    if (last_rd) state_nx = DRAIN;
      DRAIN:   if (pop && m_tlast) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // state, read address generation and the 2-stage in-flight valid/last tracker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr <= '0;
      last_addr <= '0;
      remaining <= '0;
      vld <= '0;
      lst <= '0;
    end else begin
      state <= state_nx;
      vld <= {vld[0], ram_enb};
      lst <= {lst[0], last_rd};
      if (accept) begin
        addr <= cmd_addr;
        remaining <= cmd_len;
      end else if (ram_enb) begin
        addr <= addr == ADDR_WIDTH'(DATA_DEPTH - 1) ? '0 : addr + 1'b1;
        remaining <= remaining - 1'b1;
        last_addr <= addr;
      end
    end
  end
  // FIFO pointers and occupancy; push when a tracked read's data emerges from the RAM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (vld[1]) wr_ptr <= wr_ptr == PW'(FIFO_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr == PW'(FIFO_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(vld[1]) - CW'(pop);
    end
  end
  // FIFO storage needs no reset: reads are gated by count
  always_ff @(posedge clk) begin
    if (vld[1]) mem[wr_ptr] <= {lst[1], ram_doutb};
  end
endmodule

// File: tb/tb_uram_rd_stream.sv
// tb_uram_rd_stream: directed and randomized-backpressure checks of uram_rd_stream
module tb_uram_rd_stream;
  localparam int DD = 3100;
  logic clk, rst_n, cmd_valid, cmd_ready, ram_enb, m_tvalid, m_tready, m_tlast;
  logic [13:0] cmd_addr, cmd_len, ram_addrb;
  logic [63:0] ram_doutb, m_tdata, p1, p2;
  int checks = 0, passed = 0;
  int rd_q[$];
  logic [64:0] beat_q[$];
  bit got_last;
  int outstanding = 0, credit_err = 0, stab_err = 0;
  bit prev_stall;
  logic [63:0] prev_data;
  logic prev_last;

  uram_rd_stream dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .ram_addrb(ram_addrb), .ram_enb(ram_enb),
    .ram_doutb(ram_doutb), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tdata(m_tdata), .m_tlast(m_tlast)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ram_word(input int a);
    return {16'hBEEF, 16'(a), 32'(a) * 32'h9E3779B9};
  endfunction

  function automatic logic [64:0] exp_beat(input int a, input int len, input int k);
    return {k == len, ram_word((a + k) % DD)};
  endfunction

  always @(posedge clk) begin
    p1 <= ram_enb ? ram_word(int'(ram_addrb)) : 64'hDEAD_DEAD_DEAD_DEAD;
    p2 <= p1;
  end
  assign ram_doutb = p2;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      outstanding = 0;
      prev_stall = 0;
    end else begin
      if (ram_enb) begin
        rd_q.push_back(int'(ram_addrb));
        if (outstanding >= 4) credit_err++;
      end
      if (prev_stall && (!m_tvalid || m_tdata !== prev_data || m_tlast !== prev_last)) stab_err++;
      prev_stall = m_tvalid && !m_tready;
      prev_data = m_tdata;
      prev_last = m_tlast;
      if (m_tvalid && m_tready) begin
        beat_q.push_back({m_tlast, m_tdata});
        if (m_tlast) got_last = 1;
      end
      outstanding += int'(ram_enb) - int'(m_tvalid && m_tready);
    end
  end

  task automatic run_cmd(input int a, input int len, input int mode, output bit ok, output int early_reads);
    int n;
    rd_q.delete();
    beat_q.delete();
    got_last = 0;
    early_reads = -1;
    ok = 0;
    @(negedge clk);
    cmd_valid = 1;
    cmd_addr = 14'(a);
    cmd_len = 14'(len);
    m_tready = mode == 2 ? 1'b0 : mode == 1 ? 1'($urandom_range(1)) : 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 1; i < 3000; i++) begin
      @(negedge clk);
      cmd_valid = 0;
      if (got_last) begin
        ok = 1;
        break;
      end
      if (mode == 2 && i == 18) early_reads = rd_q.size();
      m_tready = mode == 2 ? 1'(i >= 20) : mode == 1 ? 1'($urandom_range(1)) : 1'b1;
    end
  endtask

  task automatic test_reset;
    logic [81:0] act;
    rst_n = 0;
    cmd_valid = 0;
    cmd_addr = '0;
    cmd_len = '0;
    m_tready = 0;
    @(negedge clk);
    act = {cmd_ready, ram_enb, ram_addrb, m_tvalid, m_tlast, m_tdata};
    checks++;
    if (act !== '0) $display("FAIL reset_outputs: got %h expected 0", act);
    else passed++;
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_release_cmd_ready: got %b expected 1", cmd_ready);
    else passed++;
    checks++;
    if (m_tvalid !== 1'b0) $display("FAIL reset_release_tvalid: got %b expected 0", m_tvalid);
    else passed++;
  endtask

  task automatic test_basic;
    logic [81:0] act, exp;
    @(negedge clk);
    cmd_valid = 1;
    cmd_addr = 14'd10;
    cmd_len = 14'd3;
    m_tready = 1;
    checks++;
    if (cmd_ready !== 1'b1) $display("FAIL basic_cmd_ready: got %b expected 1", cmd_ready);
    else passed++;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      cmd_valid = 0;
      exp = {c == 8, c <= 4, c <= 4 ? 14'(9 + c) : 14'd13, c >= 4 && c <= 7, c == 7,
             (c >= 4 && c <= 7) ? ram_word(6 + c) : 64'h0};
      act = {cmd_ready, ram_enb, ram_addrb, m_tvalid, m_tlast, m_tvalid ? m_tdata : 64'h0};
      checks++;
      if (act !== exp) $display("FAIL basic_cycle%0d: got %h expected %h", c, act, exp);
      else passed++;
    end
  endtask

  task automatic test_wrap;
    bit ok;
    int er, errs;
    int exp_a[4] = '{3098, 3099, 0, 1};
    run_cmd(3098, 3, 0, ok, er);
    checks++;
    if (!ok) $display("FAIL wrap_done: got no last beat expected one");
    else passed++;
    errs = rd_q.size() == 4 ? 0 : 1;
    for (int k = 0; k < 4 && errs == 0; k++) if (rd_q[k] != exp_a[k]) errs++;
    checks++;
    if (errs != 0) $display("FAIL wrap_addrs: got %p expected %p", rd_q, exp_a);
    else passed++;
    errs = beat_q.size() == 4 ? 0 : 1;
    for (int k = 0; k < 4 && errs == 0; k++) if (beat_q[k] !== exp_beat(3098, 3, k)) errs++;
    checks++;
    if (errs != 0) $display("FAIL wrap_beats: got %0d beats/%0d errs expected 4/0", beat_q.size(), errs);
    else passed++;
  endtask

  task automatic test_stall;
    bit ok;
    int er, errs;
    stab_err = 0;
    run_cmd(500, 15, 2, ok, er);
    checks++;
    if (er != 4) $display("FAIL stall_reads: got %0d expected 4", er);
    else passed++;
    errs = beat_q.size() == 16 ? 0 : 1;
    for (int k = 0; k < 16 && errs == 0; k++) if (beat_q[k] !== exp_beat(500, 15, k)) errs++;
    checks++;
    if (!ok || errs != 0) $display("FAIL stall_beats: got %0d beats/%0d errs expected 16/0", beat_q.size(), errs);
    else passed++;
    checks++;
    if (stab_err != 0) $display("FAIL stall_stable: got %0d changes expected 0", stab_err);
    else passed++;
  endtask

  task automatic test_single;
    bit ok;
    int er;
    run_cmd(77, 0, 0, ok, er);
    checks++;
    if (!ok || beat_q.size() != 1 || beat_q[0] !== exp_beat(77, 0, 0))
      $display("FAIL single_beat: got %0d beats expected 1 with last data %h", beat_q.size(), exp_beat(77, 0, 0));
    else passed++;
    checks++;
    if (cmd_ready !== 1'b1) $display("FAIL single_cmd_ready: got %b expected 1", cmd_ready);
    else passed++;
  endtask

  task automatic test_random;
    bit ok;
    int er, errs, a, len;
    credit_err = 0;
    for (int t = 0; t < 100; t++) begin
      a = $urandom_range(DD - 1);
      len = $urandom_range(15);
      run_cmd(a, len, 1, ok, er);
      errs = (ok && beat_q.size() == len + 1 && rd_q.size() == len + 1) ? 0 : 1;
      for (int k = 0; k <= len && errs == 0; k++)
        if (beat_q[k] !== exp_beat(a, len, k) || rd_q[k] != (a + k) % DD) errs++;
      checks++;
      if (errs != 0) $display("FAIL random_cmd%0d: got %0d beats/%0d errs expected %0d/0", t, beat_q.size(), errs, len + 1);
      else passed++;
    end
    checks++;
    if (credit_err != 0) $display("FAIL random_credit: got %0d overruns expected 0", credit_err);
    else passed++;
  endtask

  task automatic test_reset_mid;
    bit ok;
    int er, seen;
    logic [81:0] act;
    @(negedge clk);
    cmd_valid = 1;
    cmd_addr = 14'd200;
    cmd_len = 14'd9;
    m_tready = 1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      cmd_valid = 0;
    end
    checks++;
    if (m_tvalid !== 1'b1) $display("FAIL midreset_active: got %b expected 1", m_tvalid);
    else passed++;
    rst_n = 0;
    #1;
    act = {cmd_ready, ram_enb, ram_addrb, m_tvalid, m_tlast, m_tdata};
    checks++;
    if (act !== '0) $display("FAIL midreset_outputs: got %h expected 0", act);
    else passed++;
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (m_tvalid) seen++;
    end
    checks++;
    if (seen != 0) $display("FAIL midreset_quiet: got %0d valid cycles expected 0", seen);
    else passed++;
    run_cmd(0, 1, 0, ok, er);
    checks++;
    if (!ok || beat_q.size() != 2 || beat_q[0] !== exp_beat(0, 1, 0) || beat_q[1] !== exp_beat(0, 1, 1))
      $display("FAIL midreset_next: got %0d beats expected 2 matching RAM[0..1]", beat_q.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_single();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/uram_rd_stream.md
URAM_RD_STREAM -- requirements
Module: uram_rd_stream

Interface
REQ-001 Parameter ADDR_WIDTH, default 14, width of RAM read address and command address.
REQ-002 Parameter DATA_WIDTH, default 64, width of RAM read data and stream data.
REQ-003 Parameter DATA_DEPTH, default 3100, number of valid RAM words; address wrap point.
REQ-004 Parameter FIFO_DEPTH, default 4, output buffer entries; SHALL be >= 4.
REQ-005 clk  input  1  single clock for all logic and the attached RAM read port.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 cmd_valid  input  1  read command offered.
REQ-008 cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-009 cmd_addr  input  ADDR_WIDTH  first word address, must be < DATA_DEPTH.
REQ-010 cmd_len  input  ADDR_WIDTH  word count minus one (0 = 1 word).
REQ-011 ram_addrb  output  ADDR_WIDTH  RAM read address.
REQ-012 ram_enb  output  1  RAM read enable, one word per high cycle.
REQ-013 ram_doutb  input  DATA_WIDTH  RAM read data, valid exactly 2 cycles after the enb cycle.
REQ-014 m_tvalid  output  1  stream beat valid.
REQ-015 m_tready  input  1  stream sink ready.
REQ-016 m_tdata  output  DATA_WIDTH  stream data.
REQ-017 m_tlast  output  1  marks final beat of a command.

Function
REQ-018 FSM states IDLE, READ, DRAIN; cmd_ready SHALL be 1 only in IDLE.
REQ-019 IDLE: on cmd_valid&cmd_ready, latch address := cmd_addr, remaining := cmd_len, go READ.
REQ-020 READ: assert ram_enb with ram_addrb = current address only when (fifo_count + inflight) < FIFO_DEPTH (credit rule); no data loss under any m_tready pattern.
REQ-021 Per issued read: address := address+1, or 0 when address = DATA_DEPTH-1; remaining decrements; issuing with remaining = 0 goes DRAIN.
REQ-022 A 2-stage valid/last shift register SHALL track in-flight reads; ram_doutb is written to the FIFO in the cycle its tracking bit emerges, tagged last when it was the final issued read.
REQ-023 Latency: handshake in cycle 0 -> ram_enb cycle 1 -> ram_doutb valid cycle 3 -> m_tvalid=1 cycle 4.
REQ-024 With m_tready held 1, throughput SHALL be one beat per cycle with no bubbles after the first beat.
REQ-025 m_tvalid = FIFO not empty; m_tdata/m_tlast from FIFO head; beat pops on m_tvalid&m_tready; m_tdata/m_tlast SHALL hold stable while m_tvalid&!m_tready.
REQ-026 FIFO push and pop in the same cycle SHALL leave count unchanged; count never exceeds FIFO_DEPTH.
REQ-027 DRAIN: return to IDLE in the cycle after the m_tlast beat handshakes; a new command cannot be accepted earlier.
REQ-028 ram_enb SHALL be 0 in IDLE and DRAIN; ram_addrb holds last value when ram_enb=0.

Reset
REQ-029 rst_n low asynchronously forces: state IDLE, cmd_ready=0 while rst_n low, then 1; ram_enb=0, ram_addrb=0, m_tvalid=0, m_tdata=0, m_tlast=0, FIFO count=0, in-flight tracking cleared.
REQ-030 Reset mid-command SHALL discard all in-flight and buffered data; RAM data arriving after release SHALL NOT enter the FIFO.

Verification
REQ-031 cmd_addr=10, cmd_len=3, m_tready=1 -> ram_enb cycles 1-4 on addr 10..13; beats RAM[10..13] on cycles 4-7, m_tlast only on RAM[13].
REQ-032 cmd_addr=3098, cmd_len=3 -> read addresses 3098, 3099, 0, 1 in order; 4 beats, last on word at 1.
REQ-033 cmd_len=15, m_tready=0 for 20 cycles then 1 -> exactly 4 reads issued before stall, no beat lost or duplicated, 16 beats in address order.
REQ-034 cmd_len=0 -> single beat with m_tlast=1; cmd_ready returns 1 the cycle after its handshake.
REQ-035 Random m_tready (50%) over 100 commands of random length -> scoreboard matches RAM contents, fifo_count+inflight <= 4 always.
REQ-036 rst_n pulsed low in cycle 6 of cmd_len=9 -> all outputs 0 immediately; after release no m_tvalid until next command; next command cmd_addr=0, cmd_len=1 streams RAM[0], RAM[1] correctly.
